// File: rtl/rv_trace_pkg.sv
// Shared types for the RV64I instruction-trace buffer: FSM states, capture modes
// and the packed layout of one captured entry.
package rv_trace_pkg;

  localparam int TRACE_XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_WRAP      = 2'd0;
  localparam logic [1:0] MODE_STOP_FULL = 2'd1;
  localparam logic [1:0] MODE_TRIG      = 2'd2;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           ir;
    logic [4:0]            rd;
    logic                  we;
    logic [TRACE_XLEN-1:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/rv_trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module rv_trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv_trace_buffer.sv
// Instruction-trace capture buffer: circular store of retired instructions with
// wrap, stop-when-full and PC-trigger modes, drained oldest-first via valid/ready.
module rv_trace_buffer
  import rv_trace_pkg::*;
#(
  parameter int XLEN  = TRACE_XLEN,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cap_valid,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [31:0]     cap_ir,
  input  logic [4:0]      cap_rd,
  input  logic [XLEN-1:0] cap_wdata,
  input  logic            cap_we,
  input  logic [1:0]      cfg_mode,
  input  logic [XLEN-1:0] cfg_trig_pc,
  input  logic [AW:0]     cfg_post,
  input  logic            arm,
  input  logic            stop,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_ir,
  output logic [4:0]      rd_rd,
  output logic [XLEN-1:0] rd_wdata,
  output logic            rd_we,
  output logic [AW:0]     count,
  output logic [1:0]      state,
  output logic            overflow,
  output logic            triggered
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t        state_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q, post_cnt;
  logic          overflow_q, triggered_q;
  logic [1:0]    mode_q;
  logic [XLEN-1:0] trig_pc_q;
  logic [AW:0]   post_q;

  trace_entry_t  wr_entry, rd_entry;
  logic          capturing, cap_en, full, trig_hit;

  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  // A re-arm discards any capture presented in the same cycle.
  assign cap_en    = capturing && cap_valid && !arm;
  assign full      = (count_q == FULL);
  assign trig_hit  = (state_q == ST_ARMED) && (mode_q == MODE_TRIG) && (cap_pc == trig_pc_q);

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = cap_pc;
    wr_entry.ir    = cap_ir;
    wr_entry.rd    = cap_rd;
    wr_entry.we    = cap_we;
    wr_entry.wdata = cap_wdata;
  end

  rv_trace_ram #(.DEPTH(DEPTH), .W($bits(trace_entry_t)), .AW(AW)) u_ram (
    .clock (clock),
    .we    (cap_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Configuration is captured only when an arm is accepted (not in DONE).
  always_ff @(posedge clock) begin
    if (arm && (state_q != ST_DONE)) begin
      mode_q    <= cfg_mode;
      trig_pc_q <= cfg_trig_pc;
      post_q    <= cfg_post;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      post_cnt    <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q     <= ST_ARMED;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
          end
        end
        ST_ARMED, ST_POST: begin
          if (arm) begin
            state_q     <= ST_ARMED;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
          end else begin
            if (cap_en) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (full) begin
                rd_ptr     <= rd_ptr + 1'b1;
                overflow_q <= 1'b1;
              end else begin
                count_q <= count_q + 1'b1;
              end
              if (state_q == ST_POST) begin
                post_cnt <= post_cnt - 1'b1;
                if (post_cnt == ONE) state_q <= ST_DONE;
              end else if ((mode_q == MODE_STOP_FULL) && (count_q == FULL - 1'b1)) begin
                state_q <= ST_DONE;
              end else if (trig_hit) begin
                triggered_q <= 1'b1;
                post_cnt    <= post_q;
                state_q     <= (post_q == '0) ? ST_DONE : ST_POST;
              end
            end
            // stop wins over any state change above, after the capture is written.
            if (stop) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (count_q == '0) begin
            state_q <= ST_IDLE;
          end else if (rd_ready) begin
            rd_ptr  <= rd_ptr + 1'b1;
            count_q <= count_q - 1'b1;
            if (count_q == ONE) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_valid  = (state_q == ST_DONE) && (count_q != '0);
  assign rd_pc     = rd_entry.pc;
  assign rd_ir     = rd_entry.ir;
  assign rd_rd     = rd_entry.rd;
  assign rd_we     = rd_entry.we;
  assign rd_wdata  = rd_entry.wdata;
  assign count     = count_q;
  assign state     = state_q;
  assign overflow  = overflow_q;
  assign triggered = triggered_q;

endmodule

// File: tb/tb_rv_trace_buffer.sv
// Directed bench for rv_trace_buffer: capture modes, drain order, backpressure,
// re-arm and asynchronous reset.
module tb_rv_trace_buffer;

  localparam int XLEN  = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [31:0]     cap_ir;
  logic [4:0]      cap_rd;
  logic [XLEN-1:0] cap_wdata;
  logic            cap_we;
  logic [1:0]      cfg_mode;
  logic [XLEN-1:0] cfg_trig_pc;
  logic [AW:0]     cfg_post;
  logic            arm, stop;
  logic            rd_valid, rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_ir;
  logic [4:0]      rd_rd;
  logic [XLEN-1:0] rd_wdata;
  logic            rd_we;
  logic [AW:0]     count;
  logic [1:0]      state;
  logic            overflow, triggered;

  int checks = 0;
  int passed = 0;

  rv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_ir(cap_ir), .cap_rd(cap_rd),
    .cap_wdata(cap_wdata), .cap_we(cap_we),
    .cfg_mode(cfg_mode), .cfg_trig_pc(cfg_trig_pc), .cfg_post(cfg_post),
    .arm(arm), .stop(stop),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_ir(rd_ir), .rd_rd(rd_rd), .rd_wdata(rd_wdata), .rd_we(rd_we),
    .count(count), .state(state), .overflow(overflow), .triggered(triggered)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_ir(input logic [XLEN-1:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction
  function automatic logic [XLEN-1:0] exp_wdata(input logic [XLEN-1:0] pc);
    return pc[2] ? ~pc : '0;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [XLEN-1:0] tpc, input logic [AW:0] post);
    cfg_mode = mode; cfg_trig_pc = tpc; cfg_post = post;
    arm = 1'b1;
    step();
    arm = 1'b0;
    cfg_mode = 2'd0; cfg_trig_pc = '0; cfg_post = '0;
  endtask

  task automatic capture(input logic [XLEN-1:0] pc);
    cap_valid = 1'b1; cap_pc = pc; cap_ir = exp_ir(pc); cap_rd = pc[6:2];
    cap_we = pc[2]; cap_wdata = exp_wdata(pc);
    step();
    cap_valid = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    checks++;
    if (state !== exp) $display("FAIL %s: state=%0d expected %0d", name, state, exp);
    else passed++;
  endtask

  task automatic drain(input string name, input logic [XLEN-1:0] base, input int n);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [XLEN-1:0] e;
      e = base + XLEN'(4 * i);
      checks++;
      if (rd_valid !== 1'b1 || rd_pc !== e || rd_ir !== exp_ir(e) || rd_rd !== e[6:2] ||
          rd_we !== e[2] || rd_wdata !== exp_wdata(e))
        $display("FAIL %s[%0d]: valid=%0b pc=%h ir=%h rd=%0d we=%0b expected pc=%h ir=%h rd=%0d we=%0b",
                 name, i, rd_valid, rd_pc, rd_ir, rd_rd, rd_we, e, exp_ir(e), e[6:2], e[2]);
      else passed++;
      step();
    end
    rd_ready = 1'b0;
    check_state({name, "_idle"}, 2'd0);
    checks++;
    if (count !== '0 || rd_valid !== 1'b0)
      $display("FAIL %s_empty: count=%0d rd_valid=%0b expected 0 0", name, count, rd_valid);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0 || overflow !== 1'b0 || triggered !== 1'b0)
      $display("FAIL reset: state=%0d count=%0d rd_valid=%0b ovf=%0b trig=%0b expected all 0",
               state, count, rd_valid, overflow, triggered);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    do_arm(2'd0, '0, '0);
    check_state("wrap_armed", 2'd1);
    for (int i = 0; i < 20; i++) capture(64'h1000 + 64'(4 * i));
    check_state("wrap_still_armed", 2'd1);
    do_stop();
    check_state("wrap_done", 2'd3);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b1 || triggered !== 1'b0)
      $display("FAIL wrap_flags: count=%0d ovf=%0b trig=%0b expected 16 1 0", count, overflow, triggered);
    else passed++;
    drain("wrap_drain", 64'h1010, 16);
  endtask

  task automatic test_stop_full();
    do_arm(2'd1, '0, '0);
    for (int i = 0; i < 18; i++) begin
      capture(64'h3000 + 64'(4 * i));
      if (i == 14) check_state("sf_armed_at_15", 2'd1);
      if (i == 15) check_state("sf_done_at_16", 2'd3);
    end
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0)
      $display("FAIL sf_flags: count=%0d ovf=%0b expected 16 0", count, overflow);
    else passed++;
    drain("sf_drain", 64'h3000, 16);
  endtask

  task automatic test_trig();
    do_arm(2'd2, 64'h2040, 5'd3);
    for (int i = 0; i <= 30; i++) begin
      capture(64'h2000 + 64'(4 * i));
      if (i == 16) begin
        check_state("trig_post", 2'd2);
        checks++;
        if (triggered !== 1'b1) $display("FAIL trig_flag: triggered=%0b expected 1", triggered);
        else passed++;
      end
      if (i == 18) check_state("trig_post_last", 2'd2);
      if (i == 19) check_state("trig_done", 2'd3);
    end
    checks++;
    if (count !== 5'd16 || triggered !== 1'b1)
      $display("FAIL trig_count: count=%0d trig=%0b expected 16 1", count, triggered);
    else passed++;
    drain("trig_drain", 64'h2010, 16);
  endtask

  task automatic test_trig_post0();
    do_arm(2'd2, 64'h5010, 5'd0);
    for (int i = 0; i < 5; i++) begin
      capture(64'h5000 + 64'(4 * i));
      if (i == 3) check_state("t0_armed", 2'd1);
    end
    check_state("t0_done", 2'd3);
    checks++;
    if (count !== 5'd5 || triggered !== 1'b1 || overflow !== 1'b0)
      $display("FAIL t0_flags: count=%0d trig=%0b ovf=%0b expected 5 1 0", count, triggered, overflow);
    else passed++;
    drain("t0_drain", 64'h5000, 5);
  endtask

  task automatic test_backpressure();
    logic rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [XLEN-1:0] exp_pc [5] = '{64'h6000, 64'h6004, 64'h6004, 64'h6004, 64'h6008};
    logic [AW:0] exp_cnt [5] = '{5'd2, 5'd2, 5'd2, 5'd1, 5'd0};
    do_arm(2'd0, '0, '0);
    for (int i = 0; i < 3; i++) capture(64'h6000 + 64'(4 * i));
    do_stop();
    check_state("bp_done", 2'd3);
    for (int c = 0; c < 5; c++) begin
      rd_ready = rdy[c];
      checks++;
      if (rd_valid !== 1'b1 || rd_pc !== exp_pc[c])
        $display("FAIL bp_data[%0d]: valid=%0b pc=%h expected 1 %h", c, rd_valid, rd_pc, exp_pc[c]);
      else passed++;
      step();
      checks++;
      if (count !== exp_cnt[c])
        $display("FAIL bp_count[%0d]: count=%0d expected %0d", c, count, exp_cnt[c]);
      else passed++;
    end
    rd_ready = 1'b0;
    check_state("bp_idle", 2'd0);
  endtask

  task automatic test_rearm();
    do_arm(2'd0, '0, '0);
    capture(64'h8000);
    capture(64'h8004);
    cap_valid = 1'b1; cap_pc = 64'h8008; arm = 1'b1;
    step();
    cap_valid = 1'b0; arm = 1'b0;
    check_state("rearm_armed", 2'd1);
    checks++;
    if (count !== '0) $display("FAIL rearm_count: count=%0d expected 0", count);
    else passed++;
    do_stop();
    check_state("rearm_done_empty", 2'd3);
    checks++;
    if (rd_valid !== 1'b0) $display("FAIL rearm_rdv: rd_valid=%0b expected 0", rd_valid);
    else passed++;
    step();
    check_state("rearm_idle", 2'd0);
  endtask

  task automatic test_async_reset();
    do_arm(2'd2, 64'h7008, 5'd10);
    for (int i = 0; i < 7; i++) capture(64'h7000 + 64'(4 * i));
    check_state("ar_post", 2'd2);
    checks++;
    if (count !== 5'd7 || triggered !== 1'b1)
      $display("FAIL ar_pre: count=%0d trig=%0b expected 7 1", count, triggered);
    else passed++;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0 || triggered !== 1'b0 || overflow !== 1'b0)
      $display("FAIL ar_async: state=%0d count=%0d rdv=%0b trig=%0b ovf=%0b expected all 0",
               state, count, rd_valid, triggered, overflow);
    else passed++;
    #1 reset = 1'b0;
    step();
    do_arm(2'd0, '0, '0);
    capture(64'h9000);
    capture(64'h9004);
    do_stop();
    checks++;
    if (count !== 5'd2) $display("FAIL ar_recap: count=%0d expected 2", count);
    else passed++;
    drain("ar_drain", 64'h9000, 2);
  endtask

  initial begin
    reset = 1'b0; cap_valid = 1'b0; cap_pc = '0; cap_ir = '0; cap_rd = '0;
    cap_wdata = '0; cap_we = 1'b0; cfg_mode = '0; cfg_trig_pc = '0; cfg_post = '0;
    arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    test_reset();
    test_wrap();
    test_stop_full();
    test_trig();
    test_trig_post0();
    test_backpressure();
    test_rearm();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
